uart_tx_frm: RTL and testbench
==============================

# uart_tx_frm

UART transmit framer with a small write FIFO. Software-side logic pushes bytes, and the block serialises them onto `tx` as 8-bit frames: start bit, data LSB-first, optional parity bit, then stop bit(s). Bit timing comes entirely from the `txen` strobe of the baud enable generator, so this block is the consumer end of that enable interface. It sits between the calculator result path and the UART pin.

## Interface
- `FIFO_DEPTH`, default 4: number of byte entries; must be a power of 2, from 2 to 16.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

- `clk` in 1: system clock, the same clock as the enable generator.
- `n_rst` in 1: asynchronous, active-low reset.
- `txen` in 1: one-cycle bit-time strobe, one pulse per bit period.
- `wr_en` in 1: write strobe; pushes `wr_data` when `full`=0.
- `wr_data` in 8: byte to transmit.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `ovf` out 1: one-cycle pulse when `wr_en`=1 while `full`=1.
- `busy` out 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `tx` out 1: serial line, registered, idle high.

## Operation
- **FIFO:** a circular buffer with read/write pointers and an occupancy count of width clog2(`FIFO_DEPTH`)+1.
  - A write is accepted only when `full` is 0 in that cycle. This holds even if a pop happens in the same cycle; a write while full is dropped and pulses `ovf`.
  - A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, PAR, STOP. All state and `tx` updates happen only in cycles where `txen`=1. Otherwise everything holds.
  - **IDLE:** on `txen` with the FIFO non-empty, pop the head into the shift register, set `tx` to 0, and go to START. With the FIFO empty, `tx` stays 1.
  - **START:** on `txen`, set `tx` to shreg[0], set `bitcnt` to 0, and go to DATA.
  - **DATA:** on `txen`:
    - If `bitcnt` < 7, increment `bitcnt` and set `tx` to shreg[`bitcnt`+1].
    - If `bitcnt` = 7 and `PARITY`≠0, set `tx` to the parity bit and go to PAR.
    - If `bitcnt` = 7 and `PARITY`=0, set `tx` to 1 and go to STOP with `stopcnt` = 0.
  - **PAR:** on `txen`, set `tx` to 1 and go to STOP with `stopcnt` = 0.
  - **STOP:** on `txen`:
    - If `stopcnt` < `STOP_BITS`-1, increment `stopcnt` and hold `tx` at 1.
    - Otherwise, if the FIFO is non-empty, pop, set `tx` to 0 and go to START; this gives back-to-back frames with no idle bit.
    - Otherwise go to IDLE with `tx` at 1.
- **Parity:** the parity bit is computed from the popped byte at pop time.
  - Even parity: XOR-reduce of the byte.
  - Odd parity: the inverse of that.
- **Frame length:** 1 start + 8 data + (1 if parity) + `STOP_BITS` bit periods.
- **Data latching:** `wr_data` is latched at the write. Later changes on `wr_data` do not affect queued bytes.

## Timing
- **Reset values:**
  - `tx`=1, `full`=0, `ovf`=0, `busy`=0.
  - FSM = IDLE, FIFO empty, pointers, `bitcnt` and `stopcnt` all 0.
- **Reset mid-frame:** takes effect immediately. `tx` returns to 1 asynchronously and all queued bytes are discarded.
- **Write to FIFO:**
  - A write accepted at edge N makes the entry visible from cycle N+1.
  - A `txen` in the same cycle as that first write does not start a frame. The start bit begins on the first `txen` at N+1 or later.
- **Bit timing:** each bit lasts exactly one `txen` period. `tx` changes on the clock edge where `txen`=1.
- **Flags:** `full` and `busy` are registered-count derived and reflect the count after the current edge. `ovf` is registered and asserted for the single cycle following the dropped write.
- **Stall:** if `txen` stops, the line holds its current bit indefinitely.
- **Continuous `txen`:** with `txen` tied high, one bit is sent per clock; this is legal and used in testing.

## Test plan
- **Single byte:** `PARITY`=0, `txen` every 16 clocks, write 0xA5.
  - `tx` must read 0,1,0,1,0,0,1,0,1,1 at successive `txen` edges.
  - `busy` falls after the stop bit.
- **Overflow:** `FIFO_DEPTH`=4, `txen` held low, write 0x01..0x05 on consecutive cycles.
  - `full`=1 after the 4th write.
  - The 5th write pulses `ovf` once.
  - After enabling `txen`, exactly 4 back-to-back frames 0x01..0x04 are sent with no idle bit between them.
- **Parity:** `PARITY`=1 with byte 0x07 gives parity bit 1. `PARITY`=2 with byte 0x07 gives parity bit 0. `PARITY`=1 with byte 0x00 gives parity bit 0.
- **Two stop bits:** `STOP_BITS`=2, write 0xFF and then 0x00.
  - Two high stop periods must appear before the 0x00 frame's start bit.
- **Reset mid-DATA:** assert `n_rst` low in the 4th data bit with 2 bytes queued.
  - `tx`=1 and `busy`=0 immediately.
  - After release, no frame is sent until a new write.
- **Simultaneous events:** `FIFO_DEPTH`=4 with the FIFO full, and `wr_en` coinciding with the pop on `txen`.
  - The write is dropped and `ovf` pulses.
  - The count becomes 3 and `full` falls.

Source files
------------

// File: rtl/uart_tx_frm.sv
// UART transmit framer: small byte FIFO feeding a start/data/parity/stop serialiser.
// All line activity advances only on the baud strobe txen.
module uart_tx_frm #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       txen,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       ovf,
    output logic       busy,
    output logic       tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    state;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [2:0]    bitcnt;
    logic          stopcnt;
    logic          empty, push, pop, frame_end;
    logic [7:0]    head;
    logic          head_par;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign busy      = (state != S_IDLE) || !empty;
    assign push      = wr_en && !full;
    assign frame_end = (state == S_STOP) && (stopcnt == STOP_LAST);
    assign pop       = txen && !empty && ((state == S_IDLE) || frame_end);
    assign head      = mem[rd_ptr];
    assign head_par  = (PARITY == 2) ? ~^head : ^head;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= wr_en && full;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            par_bit <= 1'b0;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
        end else if (txen) begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shreg   <= head;
                        par_bit <= head_par;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                S_START: begin
                    tx     <= shreg[0];
                    bitcnt <= '0;
                    state  <= S_DATA;
                end
                S_DATA: begin
                    if (bitcnt != 3'd7) begin
                        bitcnt <= bitcnt + 3'd1;
                        tx     <= shreg[bitcnt + 3'd1];
                    end else if (PARITY != 0) begin
                        tx    <= par_bit;
                        state <= S_PAR;
                    end else begin
                        tx      <= 1'b1;
                        stopcnt <= 1'b0;
                        state   <= S_STOP;
                    end
                end
                S_PAR: begin
                    tx      <= 1'b1;
                    stopcnt <= 1'b0;
                    state   <= S_STOP;
                end
                S_STOP: begin
                    if (!frame_end) begin
                        stopcnt <= 1'b1;
                        tx      <= 1'b1;
                    end else if (!empty) begin
                        // Chain straight into the next start bit, no idle period.
                        shreg   <= head;
                        par_bit <= head_par;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end else begin
                        tx    <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frm.sv
// Scoreboard bench for uart_tx_frm: three framings (8N1, 8E2, 8O1) share clock, strobe and reset;
// a line-decoding monitor pops expected frames and compares them bit by bit.
module tb_uart_tx_frm;

    logic       clk = 1'b0;
    logic       n_rst, txen;
    logic [2:0] wr_en;
    logic [7:0] wr_data;
    wire  [2:0] full, ovf, busy, tx;

    int nvec = 0;
    int nerr = 0;
    int mode = 0;
    int div  = 0;

    always #5 clk = ~clk;

    uart_tx_frm #(.FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .wr_en(wr_en[0]), .wr_data(wr_data),
        .full(full[0]), .ovf(ovf[0]), .busy(busy[0]), .tx(tx[0]));
    uart_tx_frm #(.FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .wr_en(wr_en[1]), .wr_data(wr_data),
        .full(full[1]), .ovf(ovf[1]), .busy(busy[1]), .tx(tx[1]));
    uart_tx_frm #(.FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .wr_en(wr_en[2]), .wr_data(wr_data),
        .full(full[2]), .ovf(ovf[2]), .busy(busy[2]), .tx(tx[2]));

    // Entry = {require_no_idle_gap, frame bits in line order}.
    logic [16:0] q0[$], q1[$], q2[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int flen(int i);
        case (i)
            0:       return 10;
            1:       return 12;
            default: return 11;
        endcase
    endfunction

    // pe / po are the hand-computed even / odd parity bits of d.
    function automatic logic [15:0] mk(int i, logic [7:0] d, logic pe, logic po);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k+1] = d[k];
        case (i)
            0: v[9] = 1'b1;
            1: begin v[9] = pe; v[10] = 1'b1; v[11] = 1'b1; end
            default: begin v[9] = po; v[10] = 1'b1; end
        endcase
        return v;
    endfunction

    task automatic qpush(int i, logic [16:0] e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpop(int i, output logic [16:0] e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        wr_en = '0;
        div   = (div + 1) % 16;
        txen  = (mode == 2) || (mode == 1 && div == 0);
    endtask

    task automatic wr(logic [2:0] m, logic [7:0] d, logic pe, logic po, logic acc, logic g);
        wr_en   = m;
        wr_data = d;
        if (acc)
            for (int i = 0; i < 3; i++)
                if (m[i]) qpush(i, {g, mk(i, d, pe, po)});
        cycle();
        wr_data = ~d;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (busy != 3'b000 && n < budget) begin
            cycle();
            n++;
        end
        chk("busy_drop", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("frames_left[%0d]", i), 32'(qsize(i)), 32'd0);
    endtask

    // Line monitor: samples each tx after every strobed edge and rebuilds frames.
    int          mcnt [3];
    int          mgap [3];
    logic [15:0] mbits[3];
    logic        mon_t;
    logic [16:0] mexp;

    initial begin
        forever begin
            @(posedge clk);
            mon_t = txen;
            @(negedge clk);
            if (!n_rst) begin
                for (int i = 0; i < 3; i++) begin mcnt[i] = 0; mgap[i] = 0; end
            end else if (mon_t) begin
                for (int i = 0; i < 3; i++) begin
                    if (mcnt[i] == 0) begin
                        if (tx[i] == 1'b0) begin
                            mbits[i] = '0;
                            mcnt[i]  = 1;
                        end else begin
                            mgap[i]++;
                        end
                    end else begin
                        mbits[i][mcnt[i]] = tx[i];
                        mcnt[i]++;
                        if (mcnt[i] == flen(i)) begin
                            chk($sformatf("frame_queued[%0d]", i), 32'(qsize(i) > 0), 32'd1);
                            if (qsize(i) > 0) begin
                                qpop(i, mexp);
                                chk($sformatf("frame_bits[%0d]", i), 32'(mbits[i]), 32'(mexp[15:0]));
                                if (mexp[16])
                                    chk($sformatf("idle_gap[%0d]", i), 32'(mgap[i]), 32'd0);
                            end
                            mcnt[i] = 0;
                            mgap[i] = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int lows;
        n_rst = 1'b0; txen = 1'b0; wr_en = '0; wr_data = '0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx[%0d]", i),   32'(tx[i]),   32'd1);
            chk($sformatf("rst_full[%0d]", i), 32'(full[i]), 32'd0);
            chk($sformatf("rst_ovf[%0d]", i),  32'(ovf[i]),  32'd0);
            chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
        end
        n_rst = 1'b1;
        cycle();

        // Single byte 0xA5, strobe every 16 clocks; 8N1 line is 0,1,0,1,0,0,1,0,1,1.
        mode = 1;
        qpush(0, 17'h0034A);
        qpush(1, {1'b0, mk(1, 8'hA5, 1'b0, 1'b1)});
        qpush(2, {1'b0, mk(2, 8'hA5, 1'b0, 1'b1)});
        wr_en = 3'b111; wr_data = 8'hA5;
        cycle();
        wr_data = 8'h00;
        chk("busy_after_write", 32'(busy), 32'h7);
        wait_idle(16 * 20);

        // Parity and stop bits with txen tied high, frames chained back to back.
        mode = 2; txen = 1'b1;
        wr(3'b111, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        wr(3'b111, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        wr(3'b111, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        wr(3'b111, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_idle(200);

        // Overflow with the strobe stopped.
        mode = 0; txen = 1'b0;
        wr(3'b111, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        wr(3'b111, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1);
        wr(3'b111, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("full_at_3", 32'(full), 32'h0);
        wr(3'b111, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("full_at_4", 32'(full), 32'h7);
        chk("ovf_before_drop", 32'(ovf), 32'h0);
        wr(3'b111, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_on_drop", 32'(ovf), 32'h7);
        chk("full_held", 32'(full), 32'h7);
        cycle();
        chk("ovf_one_cycle", 32'(ovf), 32'h0);
        mode = 1;
        wait_idle(16 * 70);

        // Full FIFO: write coinciding with the pop is still dropped.
        mode = 0; txen = 1'b0;
        wr(3'b001, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        wr(3'b001, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        wr(3'b001, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
        wr(3'b001, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sim_full", 32'(full[0]), 32'd1);
        txen = 1'b1;
        wr(3'b001, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_full_fall", 32'(full[0]), 32'd0);
        chk("sim_ovf", 32'(ovf[0]), 32'd1);
        chk("sim_start_bit", 32'(tx[0]), 32'd0);
        wr(3'b001, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sim_count3_refill", 32'(full[0]), 32'd1);
        chk("sim_ovf_clear", 32'(ovf[0]), 32'd0);
        wr(3'b001, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_ovf_again", 32'(ovf[0]), 32'd1);
        mode = 1;
        wait_idle(16 * 80);

        // Reset in the 4th data bit with a second byte queued.
        mode = 2; txen = 1'b1;
        wr(3'b111, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        wr(3'b111, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle();
        chk("busy_mid_frame", 32'(busy), 32'h7);
        n_rst = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        #1;
        chk("rst_mid_tx", 32'(tx), 32'h7);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        repeat (2) cycle();
        n_rst = 1'b1;
        lows = 0;
        repeat (40) begin
            cycle();
            if (tx != 3'b111) lows++;
        end
        chk("no_frame_after_rst", 32'(lows), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'h0);
        wr(3'b111, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
